// File: rtl/cookie_harvester_pkg.sv
// Shared types and defaults for the cookie random-bit harvester:
// pair-phase and output-register state encodings plus default parameter values.
package cookie_harvester_pkg;

    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } pair_state_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_RPT_LIMIT   = 32;

endpackage

// File: rtl/cookie_harvester_if.sv
// Valid/ready word port between the harvester (master) and its consumer (slave).
interface cookie_harvester_if #(
    parameter int WIDTH = cookie_harvester_pkg::DEF_WIDTH
);

    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             ready_i;

    modport master (output data_o, output valid_o, input ready_i);
    modport slave  (input data_o, input valid_o, output ready_i);

endinterface

// File: rtl/cookie_harvester_vn_debias.sv
// Von Neumann corrector: pairs consecutive consumed samples and emits one
// unbiased bit for each 01/10 pair; 00/11 pairs are thrown away.
module cookie_harvester_vn_debias
    import cookie_harvester_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic s,
    output logic bit_valid,
    output logic bit_val
);

    pair_state_t r_state;
    pair_state_t w_state_next;
    logic        r_b0;
    logic        w_b0_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PH_FIRST;
            r_b0    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_b0    <= w_b0_next;
        end
    end

    // Without en the phase snaps back to PH_FIRST, so a half-collected pair is lost.
    always_comb begin
        w_state_next = PH_FIRST;
        w_b0_next    = r_b0;
        bit_valid    = 1'b0;
        bit_val      = r_b0;
        if (clr) begin
            w_state_next = PH_FIRST;
            w_b0_next    = 1'b0;
        end else if (en) begin
            case (r_state)
                PH_FIRST: begin
                    w_b0_next    = s;
                    w_state_next = PH_SECOND;
                end
                PH_SECOND: begin
                    w_state_next = PH_FIRST;
                    bit_valid    = (s != r_b0);
                end
                default: w_state_next = PH_FIRST;
            endcase
        end
    end

endmodule

// File: rtl/cookie_harvester.sv
// Harvests the raw cookie bit stream: synchroniser, repetition-count health test,
// von Neumann debias, LSB-first word packing and a single-entry valid/ready output.
module cookie_harvester
    import cookie_harvester_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int RPT_LIMIT   = DEF_RPT_LIMIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               rbit,
    input  logic               clr,
    cookie_harvester_if.master out_if,
    output logic               overrun_o,
    output logic               health_fail_o
);

    localparam int RPT_W = $clog2(RPT_LIMIT + 1);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic w_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = rbit;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            // Free-running: shifts every cycle and ignores en and clr.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= rbit;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end
            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    logic [RPT_W-1:0] r_rpt;
    logic [RPT_W-1:0] w_rpt_next;
    logic             r_last_s;
    logic             r_seen;
    logic             r_health_fail;

    always_comb begin
        w_rpt_next = r_rpt;
        if (en) begin
            if (!r_seen || (w_s != r_last_s)) begin
                w_rpt_next = RPT_W'(1);
            end else if (r_rpt != RPT_W'(RPT_LIMIT)) begin
                w_rpt_next = r_rpt + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt         <= '0;
            r_last_s      <= 1'b0;
            r_seen        <= 1'b0;
            r_health_fail <= 1'b0;
        end else if (clr) begin
            r_rpt         <= '0;
            r_last_s      <= 1'b0;
            r_seen        <= 1'b0;
            r_health_fail <= 1'b0;
        end else if (en) begin
            r_rpt    <= w_rpt_next;
            r_last_s <= w_s;
            r_seen   <= 1'b1;
            if (w_rpt_next == RPT_W'(RPT_LIMIT)) begin
                r_health_fail <= 1'b1;
            end
        end
    end

    logic w_bit_valid;
    logic w_bit_val;

    cookie_harvester_vn_debias u_debias (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .en        (en),
        .s         (w_s),
        .bit_valid (w_bit_valid),
        .bit_val   (w_bit_val)
    );

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_word;
    logic [CNT_W-1:0] r_cnt;
    logic             w_emit;
    logic             w_last;
    logic             w_complete;

    // A failed source freezes the packer so no word can complete until clr.
    assign w_emit     = w_bit_valid & ~r_health_fail;
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_complete = w_emit & w_last;

    always_comb begin
        w_word        = r_shift;
        w_word[r_cnt] = w_bit_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (clr) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_emit) begin
            r_shift <= w_word;
            r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    out_state_t       r_out_state;
    out_state_t       w_out_next;
    logic [WIDTH-1:0] r_data;
    logic             r_overrun;
    logic             w_load;
    logic             w_drop;
    logic             w_accept;

    // An accept in the completion cycle frees the slot, so the new word loads with no bubble.
    always_comb begin
        w_out_next = r_out_state;
        w_load     = 1'b0;
        w_drop     = 1'b0;
        w_accept   = (r_out_state == OUT_FULL) && out_if.ready_i;
        if (w_complete) begin
            if ((r_out_state == OUT_EMPTY) || out_if.ready_i) begin
                w_load     = 1'b1;
                w_out_next = OUT_FULL;
            end else begin
                w_drop = 1'b1;
            end
        end else if (w_accept) begin
            w_out_next = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_state <= OUT_EMPTY;
            r_overrun   <= 1'b0;
        end else if (clr) begin
            r_out_state <= OUT_EMPTY;
            r_overrun   <= 1'b0;
        end else begin
            r_out_state <= w_out_next;
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // clr leaves the last word visible on data_o; only reset wipes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (!clr && w_load) begin
            r_data <= w_word;
        end
    end

    assign out_if.data_o  = r_data;
    assign out_if.valid_o = (r_out_state == OUT_FULL);
    assign overrun_o      = r_overrun;
    assign health_fail_o  = r_health_fail;

endmodule
